// File: rtl/p1_bus_master_seq_if.sv
// P1 requester/bus signal bundle: CPU and DMA request ports plus the Multibus command pins.
// The master modport is the sequencer's view; slave is the CPU/DMA/arbiter/memory side.
interface p1_bus_master_seq_if;
  logic p1init_n;
  logic cpu_req;
  logic cpu_wr;
  logic dma_req;
  logic dma_wr;
  logic cpu_ack;
  logic dma_ack;
  logic cpu_berr;
  logic dma_berr;
  logic sel_dma;
  logic sysb;
  logic aen;
  logic cmd_oe;
  logic mrdc_n;
  logic mwtc_n;
  logic xack_n;

  modport master (
    input  p1init_n, cpu_req, cpu_wr, dma_req, dma_wr, aen, xack_n,
    output cpu_ack, dma_ack, cpu_berr, dma_berr, sel_dma, sysb, cmd_oe, mrdc_n, mwtc_n
  );

  modport slave (
    output p1init_n, cpu_req, cpu_wr, dma_req, dma_wr, aen, xack_n,
    input  cpu_ack, dma_ack, cpu_berr, dma_berr, sel_dma, sysb, cmd_oe, mrdc_n, mwtc_n
  );
endinterface

// File: rtl/p1_bus_master_seq.sv
// P1 master sequencer: round-robin CPU/DMA, SYSB/AEN handshake, one MRDC/MWTC cycle with XACK timeout.
// Latency: req->sysb 1 clk, strobe width k+2 for XACK at clk k; requesters hold req until ack/berr.
module p1_bus_master_seq #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                CLK,
  input  logic                RESET_n,
  p1_bus_master_seq_if.master bus
);

  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_SETUP = 3'd2,
    ST_CMD   = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_dma_q, sel_dma_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic       last_dma_q, last_dma_d;
  logic       win_dma;

  logic       sysb_q, sysb_d;
  logic       cmd_oe_q, cmd_oe_d;
  logic       mrdc_n_q, mrdc_n_d;
  logic       mwtc_n_q, mwtc_n_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       dma_ack_q, dma_ack_d;
  logic       cpu_berr_q, cpu_berr_d;
  logic       dma_berr_q, dma_berr_d;

  logic       aen_s1_q, aen_s2_q;
  logic       xack_s1_q, xack_s2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_dma_d  = sel_dma_q;
    dir_d      = dir_q;
    err_d      = err_q;
    last_dma_d = last_dma_q;
    win_dma    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          // On a tie the side that did not win last time goes first.
          win_dma   = bus.dma_req && (!bus.cpu_req || !last_dma_q);
          sel_dma_d = win_dma;
          dir_d     = win_dma ? bus.dma_wr : bus.cpu_wr;
          err_d     = 1'b0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (aen_s2_q) begin
          state_d = ST_SETUP;
          cnt_d   = 8'd0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = ST_CMD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CMD: begin
        if (!xack_s2_q) begin
          state_d = ST_HOLD;
          err_d   = 1'b0;
          cnt_d   = 8'd0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_HOLD;
          err_d   = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        last_dma_d = sel_dma_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // INIT drops the cycle without completing it; fairness history is kept.
    if (!bus.p1init_n) begin
      state_d    = ST_IDLE;
      cnt_d      = 8'd0;
      sel_dma_d  = sel_dma_q;
      dir_d      = dir_q;
      last_dma_d = last_dma_q;
    end

    sysb_d     = (state_d == ST_REQ) || (state_d == ST_SETUP) ||
                 (state_d == ST_CMD) || (state_d == ST_HOLD);
    cmd_oe_d   = (state_d == ST_SETUP) || (state_d == ST_CMD) || (state_d == ST_HOLD);
    mwtc_n_d   = !((state_d == ST_CMD) && dir_d);
    mrdc_n_d   = !((state_d == ST_CMD) && !dir_d);
    cpu_ack_d  = (state_d == ST_DONE) && !sel_dma_d && !err_d;
    dma_ack_d  = (state_d == ST_DONE) &&  sel_dma_d && !err_d;
    cpu_berr_d = (state_d == ST_DONE) && !sel_dma_d &&  err_d;
    dma_berr_d = (state_d == ST_DONE) &&  sel_dma_d &&  err_d;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      sel_dma_q  <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      last_dma_q <= 1'b1;
      sysb_q     <= 1'b0;
      cmd_oe_q   <= 1'b0;
      mrdc_n_q   <= 1'b1;
      mwtc_n_q   <= 1'b1;
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      cpu_berr_q <= 1'b0;
      dma_berr_q <= 1'b0;
      aen_s1_q   <= 1'b0;
      aen_s2_q   <= 1'b0;
      xack_s1_q  <= 1'b1;
      xack_s2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_dma_q  <= sel_dma_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      last_dma_q <= last_dma_d;
      sysb_q     <= sysb_d;
      cmd_oe_q   <= cmd_oe_d;
      mrdc_n_q   <= mrdc_n_d;
      mwtc_n_q   <= mwtc_n_d;
      cpu_ack_q  <= cpu_ack_d;
      dma_ack_q  <= dma_ack_d;
      cpu_berr_q <= cpu_berr_d;
      dma_berr_q <= dma_berr_d;
      aen_s1_q   <= bus.aen;
      aen_s2_q   <= aen_s1_q;
      xack_s1_q  <= bus.xack_n;
      xack_s2_q  <= xack_s1_q;
    end
  end

  assign bus.sysb     = sysb_q;
  assign bus.cmd_oe   = cmd_oe_q;
  assign bus.mrdc_n   = mrdc_n_q;
  assign bus.mwtc_n   = mwtc_n_q;
  assign bus.sel_dma  = sel_dma_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.dma_ack  = dma_ack_q;
  assign bus.cpu_berr = cpu_berr_q;
  assign bus.dma_berr = dma_berr_q;

endmodule

// File: tb/tb_p1_bus_master_seq.sv
// Directed plus randomized bench: arbiter and memory responders, a monitor, and a
// transaction-level expectation of who is served, strobe width and ack vs berr.
module tb_p1_bus_master_seq;
  localparam int TO = 16;

  logic CLK = 1'b0;
  logic RESET_n;
  always #5 CLK = ~CLK;

  p1_bus_master_seq_if bus ();

  p1_bus_master_seq #(.SETUP_CYC(2), .HOLD_CYC(1), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  int aen_dly = 2;
  bit aen_drop = 0;
  int acnt = 0;
  int resp_k = 0;
  int scnt = 0;
  bit last_dma_m = 1;

  bit in_strobe = 0;
  int sw = 0;
  bit stype = 0;
  bit ssel = 0;
  int viol = 0;
  int n_pulse = 0;
  logic prev_sysb = 1'b0;
  logic prev_sel = 1'b0;

  // Arbiter: grant AEN a programmable number of clocks after SYSB.
  always @(negedge CLK) begin
    if (bus.sysb === 1'b1 && !(aen_drop && (bus.mrdc_n === 1'b0 || bus.mwtc_n === 1'b0))) begin
      acnt++;
      if (acnt >= aen_dly) bus.aen = 1'b1;
    end else begin
      if (bus.sysb !== 1'b1) acnt = 0;
      bus.aen = 1'b0;
    end
  end

  // Memory: XACK low at clock resp_k after the strobe; resp_k==0 never answers.
  always @(negedge CLK) begin
    if (bus.mrdc_n === 1'b0 || bus.mwtc_n === 1'b0) begin
      scnt++;
      if (resp_k != 0 && scnt == resp_k) bus.xack_n = 1'b0;
    end else begin
      scnt = 0;
      bus.xack_n = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (bus.mrdc_n === 1'b0 || bus.mwtc_n === 1'b0) begin
      if (!in_strobe) begin
        sw = 0;
        stype = (bus.mwtc_n === 1'b0);
        ssel = bus.sel_dma;
      end
      in_strobe = 1;
      sw++;
    end else begin
      in_strobe = 0;
    end
    if (bus.mrdc_n === 1'b0 && bus.mwtc_n === 1'b0) viol++;
    if ((bus.mrdc_n === 1'b0 || bus.mwtc_n === 1'b0) && bus.cmd_oe !== 1'b1) viol++;
    if (int'(bus.cpu_ack) + int'(bus.dma_ack) + int'(bus.cpu_berr) + int'(bus.dma_berr) > 1) viol++;
    if (prev_sysb === 1'b1 && bus.sysb === 1'b1 && bus.sel_dma !== prev_sel) viol++;
    n_pulse += int'(bus.cpu_ack === 1'b1) + int'(bus.dma_ack === 1'b1) +
               int'(bus.cpu_berr === 1'b1) + int'(bus.dma_berr === 1'b1);
    prev_sysb = bus.sysb;
    prev_sel  = bus.sel_dma;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_for(input int what, input string tag);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (what == 0) hit = (bus.cmd_oe === 1'b1);
      else           hit = (bus.mrdc_n === 1'b0 || bus.mwtc_n === 1'b0);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic serve_expect(input bit exp_dma, input bit exp_wr, input int k, input string tag);
    bit got = 0;
    bit exp_err;
    int exp_w;
    logic [3:0] pv = 4'd0;
    logic [3:0] ev;
    resp_k  = k;
    exp_err = (k == 0) || (k + 2 > TO);
    exp_w   = exp_err ? TO : k + 2;
    ev = exp_err ? (exp_dma ? 4'b0001 : 4'b0010) : (exp_dma ? 4'b0100 : 4'b1000);
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      pv = {bus.cpu_ack, bus.dma_ack, bus.cpu_berr, bus.dma_berr};
      if (pv !== 4'd0) got = 1;
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_pulse"}, 32'(pv), 32'(ev));
    check({tag, "_width"}, 32'(sw), 32'(exp_w));
    check({tag, "_wr"}, 32'(stype), 32'(exp_wr));
    check({tag, "_sel"}, 32'(ssel), 32'(exp_dma));
    check({tag, "_viol"}, 32'(viol), 32'd0);
    if (exp_dma) bus.dma_req = 1'b0;
    else         bus.cpu_req = 1'b0;
    last_dma_m = exp_dma;
  endtask

  task automatic run_round(input bit rc, input bit rd, input bit wc, input bit wd,
                           input int kc, input int kd, input string tag);
    bit first_dma;
    // Alternation: on a tie the side not served last time goes first.
    if (rc && rd) first_dma = !last_dma_m;
    else          first_dma = rd;
    bus.cpu_wr = wc;
    bus.dma_wr = wd;
    bus.cpu_req = rc;
    bus.dma_req = rd;
    serve_expect(first_dma, first_dma ? wd : wc, first_dma ? kd : kc, {tag, "_a"});
    if (rc && rd)
      serve_expect(!first_dma, first_dma ? wc : wd, first_dma ? kc : kd, {tag, "_b"});
    step();
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    bus.p1init_n = 1'b1;
    step();
    step();
    RESET_n = 1'b1;
    last_dma_m = 1;
    step();
  endtask

  initial begin
    int np;
    int mode;
    RESET_n = 1'b0;
    bus.p1init_n = 1'b1;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.dma_wr = 1'b0;
    repeat (3) step();
    check("rst_sysb", 32'(bus.sysb), 32'd0);
    check("rst_cmd_oe", 32'(bus.cmd_oe), 32'd0);
    check("rst_strobes", 32'({bus.mrdc_n, bus.mwtc_n}), 32'd3);
    check("rst_acks", 32'({bus.cpu_ack, bus.dma_ack, bus.cpu_berr, bus.dma_berr}), 32'd0);
    check("rst_sel", 32'(bus.sel_dma), 32'd0);
    RESET_n = 1'b1;
    step();

    // CPU read alone, AEN 3 clocks after SYSB, XACK at clock 4 of CMD.
    aen_dly = 3;
    resp_k = 4;
    bus.cpu_wr = 1'b0;
    bus.cpu_req = 1'b1;
    step();
    check("t1_sysb_1clk", 32'(bus.sysb), 32'd1);
    check("t1_sel", 32'(bus.sel_dma), 32'd0);
    serve_expect(1'b0, 1'b0, 4, "t1");

    // Simultaneous requests after reset alternate CPU, DMA, CPU...
    do_reset();
    aen_dly = 2;
    for (int r = 0; r < 3; r++)
      run_round(1, 1, r[0], !r[0], 3 + r, 2 + r, "t2");

    // DMA write with no XACK times out.
    run_round(0, 1, 0, 1, 0, 0, "t3");
    check("t3_sysb_off", 32'(bus.sysb), 32'd0);
    check("t3_cmd_oe_off", 32'(bus.cmd_oe), 32'd0);

    // XACK seen on the last timeout clock wins; one clock later is an error.
    run_round(1, 0, 1, 0, 14, 0, "tie_xack");
    run_round(0, 1, 0, 0, 0, 15, "late_xack");

    // INIT during CMD aborts without ack; the held request runs again.
    resp_k = 0;
    bus.cpu_wr = 1'b1;
    bus.cpu_req = 1'b1;
    wait_for(1, "t4_strobe");
    step();
    np = n_pulse;
    bus.p1init_n = 1'b0;
    step();
    check("t4_strobes_off", 32'({bus.mrdc_n, bus.mwtc_n}), 32'd3);
    check("t4_sysb_off", 32'(bus.sysb), 32'd0);
    check("t4_cmd_oe_off", 32'(bus.cmd_oe), 32'd0);
    step();
    bus.p1init_n = 1'b1;
    resp_k = 3;
    step();
    check("t4_no_pulse", 32'(n_pulse), 32'(np));
    serve_expect(1'b0, 1'b1, 3, "t4_rerun");
    step();

    // Asynchronous reset during SETUP of a DMA cycle.
    resp_k = 2;
    bus.dma_wr = 1'b0;
    bus.dma_req = 1'b1;
    wait_for(0, "t5_setup");
    RESET_n = 1'b0;
    #1;
    check("t5_async_sysb", 32'(bus.sysb), 32'd0);
    check("t5_async_cmd_oe", 32'(bus.cmd_oe), 32'd0);
    check("t5_async_sel", 32'(bus.sel_dma), 32'd0);
    check("t5_async_strobes", 32'({bus.mrdc_n, bus.mwtc_n}), 32'd3);
    step();
    step();
    RESET_n = 1'b1;
    last_dma_m = 1;
    serve_expect(1'b1, 1'b0, 2, "t5_rerun");
    step();

    // AEN dropping while the strobe is active does not stop the cycle.
    aen_drop = 1;
    run_round(1, 0, 0, 0, 5, 0, "t5_aen_drop");
    aen_drop = 0;

    for (int r = 0; r < 12; r++) begin
      mode = int'($urandom_range(0, 2));
      aen_dly = int'($urandom_range(1, 4));
      run_round(mode != 1, mode != 0, 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 17)), int'($urandom_range(0, 17)), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
